// File: rtl/midi_pkg.sv
// Shared constants, sequencer state type and the one-hot decoder used by the
// MIDI note transmitter.
package midi_pkg;

  localparam int w_note = 12;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    OFF_MSG,
    ON_MSG
  } seq_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] index;
  } onehot_t;

  // Index of the set bit; valid only when exactly one bit is set.
  function automatic onehot_t onehot_index(input logic [w_note-1:0] v);
    onehot_t r;
    r = '0;
    for (int i = 0; i < w_note; i++) begin
      if (v[i]) r.index = 4'(i);
    end
    r.valid = ($countones(v) == 1);
    return r;
  endfunction

endpackage

// File: rtl/note_midi_tx_if.sv
// Note-input / MIDI-output bundle between the note detector, this block and
// the MIDI OUT pin.
interface note_midi_tx_if;
  import midi_pkg::*;

  logic [w_note-1:0] i_note;
  logic              o_tx;
  logic              o_busy;
  logic [6:0]        o_key;
  logic              o_key_valid;

  modport slave (
    input  i_note,
    output o_tx, o_busy, o_key, o_key_valid
  );

  modport master (
    output i_note,
    input  o_tx, o_busy, o_key, o_key_valid
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a valid/ready input; accepts the next byte
// in the last cycle of a stop bit so frames can run back-to-back.
module uart_tx_byte #(
  parameter int divisor = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int             CW        = (divisor > 1) ? $clog2(divisor) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(divisor - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          bit_end, frame_end;

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    bit_end   = busy_q && (baud_q == BAUD_LAST);
    frame_end = bit_end && (bit_q == 4'd9);
    ready_o   = !busy_q || frame_end;

    if (valid_i && ready_o) begin
      shift_d = {1'b1, data_i, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
    end else if (bit_end) begin
      // Shifting in ones leaves the line parked high once the frame ends.
      baud_d  = '0;
      shift_d = {1'b1, shift_q[9:1]};
      bit_d   = frame_end ? 4'd0 : bit_q + 4'd1;
      busy_d  = !frame_end;
    end else if (busy_q) begin
      baud_d = baud_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_o = shift_q[0];

endmodule

// File: rtl/note_midi_tx.sv
// Turns a filtered one-hot pitch-class vector into MIDI Note Off / Note On
// messages, tracking the single key currently sounding.
module note_midi_tx
  import midi_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int baud     = 31250,
  parameter int channel  = 0,
  parameter int base_key = 60,
  parameter int velocity = 100
) (
  input logic           clk,
  input logic           rst,
  note_midi_tx_if.slave bus
);

  localparam int divisor = clk_mhz * 1000000 / baud;

  if (base_key > 116) begin : g_bad_base_key
    $error("note_midi_tx: base_key must be <= 116");
  end
  if (channel < 0 || channel > 15) begin : g_bad_channel
    $error("note_midi_tx: channel must be 0..15");
  end
  if (velocity < 1 || velocity > 127) begin : g_bad_velocity
    $error("note_midi_tx: velocity must be 1..127");
  end
  if (divisor < 1) begin : g_bad_divisor
    $error("note_midi_tx: baud too high for clock");
  end

  localparam logic [3:0] CH  = 4'(channel);
  localparam logic [6:0] KEY = 7'(base_key);
  localparam logic [7:0] VEL = 8'(velocity);

  logic [w_note-1:0] note_q;
  seq_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        tgt_key_q, tgt_key_d;
  logic              tgt_valid_q, tgt_valid_d;
  logic [6:0]        key_q, key_d;
  logic              key_valid_q, key_valid_d;

  onehot_t    oh;
  logic [6:0] dec_key;
  logic       differ;
  logic       tx_valid, tx_ready, tx_line;
  logic [7:0] tx_data;

  always_comb begin
    oh      = onehot_index(note_q);
    dec_key = KEY + (7'd11 - 7'(oh.index));
    differ  = (oh.valid != key_valid_q) || (oh.valid && (dec_key != key_q));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tgt_key_d   = tgt_key_q;
    tgt_valid_d = tgt_valid_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    tx_valid    = 1'b0;
    tx_data     = '0;

    unique case (state_q)
      IDLE: begin
        if (differ) begin
          tgt_key_d   = dec_key;
          tgt_valid_d = oh.valid;
          idx_d       = 2'd0;
          state_d     = key_valid_q ? OFF_MSG : ON_MSG;
        end
      end

      OFF_MSG: begin
        // Slot 3 drains the final frame so busy holds through its stop bit.
        if (idx_q == 2'd3) begin
          if (tx_ready) begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end
        end else begin
          tx_valid = 1'b1;
          case (idx_q)
            2'd0:    tx_data = {NOTE_OFF, CH};
            2'd1:    tx_data = {1'b0, key_q};
            default: tx_data = 8'h00;
          endcase
          if (tx_ready) begin
            if (idx_q == 2'd2) begin
              key_valid_d = 1'b0;
              if (tgt_valid_q) begin
                state_d = ON_MSG;
                idx_d   = 2'd0;
              end else begin
                idx_d = 2'd3;
              end
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end

      ON_MSG: begin
        if (idx_q == 2'd3) begin
          if (tx_ready) begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end
        end else begin
          tx_valid = 1'b1;
          case (idx_q)
            2'd0:    tx_data = {NOTE_ON, CH};
            2'd1:    tx_data = {1'b0, tgt_key_q};
            default: tx_data = VEL;
          endcase
          if (tx_ready) begin
            if (idx_q == 2'd0) begin
              key_d       = tgt_key_q;
              key_valid_d = 1'b1;
            end
            idx_d = (idx_q == 2'd2) ? 2'd3 : idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_q      <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      tgt_key_q   <= '0;
      tgt_valid_q <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      note_q      <= bus.i_note;
      state_q     <= state_d;
      idx_q       <= idx_d;
      tgt_key_q   <= tgt_key_d;
      tgt_valid_q <= tgt_valid_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  uart_tx_byte #(
    .divisor(divisor)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .valid_i(tx_valid),
    .data_i (tx_data),
    .ready_o(tx_ready),
    .tx_o   (tx_line)
  );

  assign bus.o_tx        = tx_line;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_key       = key_q;
  assign bus.o_key_valid = key_valid_q;

endmodule

// File: tb/tb_note_midi_tx.sv
// Directed bench for note_midi_tx: a UART monitor decodes the MIDI line and
// each scenario task compares the decoded bytes and status outputs.
module tb_note_midi_tx;

  // Fast bit rate (divisor 16) keeps every scenario short.
  localparam int CLK_MHZ = 1;
  localparam int BAUD    = 62500;
  localparam int D       = 16;
  localparam int FRAME   = 10 * D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] rx_byte  [$];
  int         rx_start [$];
  bit         rx_bad   [$];

  note_midi_tx_if bus ();

  note_midi_tx #(
    .clk_mhz(CLK_MHZ),
    .baud   (BAUD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: a frame starts on the first low sample; every bit must be
  // stable for exactly D cycles; frames cut by reset are discarded.
  initial begin
    logic [9:0] f;
    bit         bad, abort;
    int         s;
    forever begin
      @(negedge clk);
      if (rst && bus.o_tx === 1'b0) begin
        s = cyc; bad = 0; abort = 0; f = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < D; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst) abort = 1;
            if (c == 0) f[b] = bus.o_tx;
            else if (bus.o_tx !== f[b]) bad = 1;
          end
        end
        if (!abort) begin
          if (f[0] !== 1'b0 || f[9] !== 1'b1) bad = 1;
          rx_byte.push_back(f[8:1]);
          rx_start.push_back(s);
          rx_bad.push_back(bad);
        end
      end
    end
  end

  task automatic clear_rx();
    rx_byte.delete();
    rx_start.delete();
    rx_bad.delete();
  endtask

  // Waits until o_busy has been low for 4 consecutive samples.
  task automatic wait_quiet(input int max_cyc, output int fall_cyc, output bit timeout);
    int low;
    low = 0; timeout = 1; fall_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) begin
        if (low == 0) fall_cyc = cyc;
        low++;
        if (low == 4) begin
          timeout = 0;
          break;
        end
      end else begin
        low = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_note = '0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.o_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", bus.o_tx); end
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_cmp++;
    if (bus.o_key !== 7'd0) begin n_bad++; $display("FAIL reset_key: got %0d want 0", bus.o_key); end
    n_cmp++;
    if (bus.o_key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_kv: got %b want 0", bus.o_key_valid); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_line();
    int bad;
    bad = 0;
    clear_rx();
    bus.i_note = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_key_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || rx_byte.size() != 0) begin
      n_bad++; $display("FAIL idle_line: got %0d bad cycles, %0d bytes want 0, 0", bad, rx_byte.size());
    end
  endtask

  task automatic test_first_note();
    logic [7:0] exp [3] = '{8'h90, 8'h3C, 8'h64};
    int  fall;
    bit  to;
    clear_rx();
    bus.i_note = 12'h800;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL first_busy_k: got %b want 0", bus.o_busy); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.o_busy !== 1'b1 || bus.o_tx !== 1'b1) begin
      n_bad++; $display("FAIL first_k1: got busy %b tx %b want 1 1", bus.o_busy, bus.o_tx);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.o_tx !== 1'b0) begin n_bad++; $display("FAIL first_tx_fall_k2: got %b want 0", bus.o_tx); end
    n_cmp++;
    if (bus.o_key !== 7'd60 || bus.o_key_valid !== 1'b1) begin
      n_bad++; $display("FAIL first_key_set: got %0d/%b want 60/1", bus.o_key, bus.o_key_valid);
    end
    wait_quiet(4000, fall, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL first_timeout: got busy stuck want idle"); end
    n_cmp++;
    if (rx_byte.size() != 3) begin
      n_bad++; $display("FAIL first_count: got %0d bytes want 3", rx_byte.size());
    end
    for (int i = 0; i < 3 && i < rx_byte.size(); i++) begin
      n_cmp++;
      if (rx_byte[i] !== exp[i] || rx_bad[i]) begin
        n_bad++; $display("FAIL first_byte%0d: got %02h (framing %b) want %02h", i, rx_byte[i], rx_bad[i], exp[i]);
      end
    end
    if (rx_byte.size() == 3) begin
      n_cmp++;
      if (rx_start[1] - rx_start[0] != FRAME || rx_start[2] - rx_start[1] != FRAME) begin
        n_bad++; $display("FAIL first_spacing: got %0d,%0d want %0d", rx_start[1] - rx_start[0], rx_start[2] - rx_start[1], FRAME);
      end
      n_cmp++;
      if (fall - rx_start[0] != 3 * FRAME) begin
        n_bad++; $display("FAIL first_busy_fall: got %0d want %0d", fall - rx_start[0], 3 * FRAME);
      end
    end
  endtask

  task automatic test_note_change();
    logic [7:0] exp [6] = '{8'h80, 8'h3C, 8'h00, 8'h90, 8'h45, 8'h64};
    int  fall;
    bit  to;
    clear_rx();
    bus.i_note = 12'h004;
    repeat (3) @(negedge clk);
    wait_quiet(6000, fall, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL change_timeout: got busy stuck want idle"); end
    n_cmp++;
    if (rx_byte.size() != 6) begin
      n_bad++; $display("FAIL change_count: got %0d bytes want 6", rx_byte.size());
    end
    for (int i = 0; i < 6 && i < rx_byte.size(); i++) begin
      n_cmp++;
      if (rx_byte[i] !== exp[i] || rx_bad[i]) begin
        n_bad++; $display("FAIL change_byte%0d: got %02h (framing %b) want %02h", i, rx_byte[i], rx_bad[i], exp[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (rx_start[i] - rx_start[i-1] != FRAME) begin
          n_bad++; $display("FAIL change_gap%0d: got %0d want %0d", i, rx_start[i] - rx_start[i-1], FRAME);
        end
      end
    end
    if (rx_byte.size() == 6) begin
      n_cmp++;
      if (fall - rx_start[0] != 6 * FRAME) begin
        n_bad++; $display("FAIL change_busy_fall: got %0d want %0d", fall - rx_start[0], 6 * FRAME);
      end
    end
    n_cmp++;
    if (bus.o_key !== 7'd69 || bus.o_key_valid !== 1'b1) begin
      n_bad++; $display("FAIL change_key: got %0d/%b want 69/1", bus.o_key, bus.o_key_valid);
    end
  endtask

  task automatic test_release();
    logic [7:0] exp [3] = '{8'h80, 8'h45, 8'h00};
    int  fall;
    bit  to;
    clear_rx();
    bus.i_note = 12'h000;
    repeat (3) @(negedge clk);
    wait_quiet(4000, fall, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL release_timeout: got busy stuck want idle"); end
    n_cmp++;
    if (rx_byte.size() != 3) begin
      n_bad++; $display("FAIL release_count: got %0d bytes want 3", rx_byte.size());
    end
    for (int i = 0; i < 3 && i < rx_byte.size(); i++) begin
      n_cmp++;
      if (rx_byte[i] !== exp[i] || rx_bad[i]) begin
        n_bad++; $display("FAIL release_byte%0d: got %02h (framing %b) want %02h", i, rx_byte[i], rx_bad[i], exp[i]);
      end
    end
    if (rx_byte.size() == 3) begin
      n_cmp++;
      if (fall - rx_start[0] != 3 * FRAME) begin
        n_bad++; $display("FAIL release_busy_fall: got %0d want %0d", fall - rx_start[0], 3 * FRAME);
      end
    end
    n_cmp++;
    if (bus.o_key_valid !== 1'b0) begin n_bad++; $display("FAIL release_kv: got %b want 0", bus.o_key_valid); end
  endtask

  task automatic test_skip();
    logic [7:0] exp [9] = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00, 8'h90, 8'h43, 8'h64};
    int  fall, n40;
    bit  to;
    clear_rx();
    bus.i_note = 12'h800;
    repeat (100) @(negedge clk);
    bus.i_note = 12'h080;
    repeat (100) @(negedge clk);
    bus.i_note = 12'h010;
    wait_quiet(8000, fall, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL skip_timeout: got busy stuck want idle"); end
    n_cmp++;
    if (rx_byte.size() != 9) begin
      n_bad++; $display("FAIL skip_count: got %0d bytes want 9", rx_byte.size());
    end
    n40 = 0;
    for (int i = 0; i < rx_byte.size(); i++) if (rx_byte[i] == 8'h40) n40++;
    n_cmp++;
    if (n40 != 0) begin n_bad++; $display("FAIL skip_no_e: got %0d bytes of 40 want 0", n40); end
    for (int i = 0; i < 9 && i < rx_byte.size(); i++) begin
      n_cmp++;
      if (rx_byte[i] !== exp[i] || rx_bad[i]) begin
        n_bad++; $display("FAIL skip_byte%0d: got %02h (framing %b) want %02h", i, rx_byte[i], rx_bad[i], exp[i]);
      end
    end
    n_cmp++;
    if (bus.o_key !== 7'd67 || bus.o_key_valid !== 1'b1) begin
      n_bad++; $display("FAIL skip_key: got %0d/%b want 67/1", bus.o_key, bus.o_key_valid);
    end
  endtask

  task automatic test_ambiguous();
    logic [7:0] exp [3] = '{8'h80, 8'h43, 8'h00};
    int  fall, busy_seen;
    bit  to;
    clear_rx();
    bus.i_note = 12'h801;
    repeat (3) @(negedge clk);
    wait_quiet(4000, fall, to);
    n_cmp++;
    if (to || rx_byte.size() != 3) begin
      n_bad++; $display("FAIL ambig_count: got %0d bytes (timeout %b) want 3", rx_byte.size(), to);
    end
    for (int i = 0; i < 3 && i < rx_byte.size(); i++) begin
      n_cmp++;
      if (rx_byte[i] !== exp[i]) begin
        n_bad++; $display("FAIL ambig_byte%0d: got %02h want %02h", i, rx_byte[i], exp[i]);
      end
    end
    n_cmp++;
    if (bus.o_key_valid !== 1'b0) begin n_bad++; $display("FAIL ambig_kv: got %b want 0", bus.o_key_valid); end
    clear_rx();
    busy_seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b0) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0 || rx_byte.size() != 0) begin
      n_bad++; $display("FAIL ambig_silent: got %0d busy cycles, %0d bytes want 0, 0", busy_seen, rx_byte.size());
    end
    bus.i_note = 12'h000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_byte();
    int  bad, waited;
    clear_rx();
    bus.i_note = 12'h800;
    waited = 0;
    while (bus.o_tx !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited >= 50) begin n_bad++; $display("FAIL rstmid_start: got no start bit want start within 50"); end
    repeat (D + D / 2) @(negedge clk);
    n_cmp++;
    if (bus.o_tx !== 1'b0 || bus.o_key_valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: got tx %b kv %b want 0 1", bus.o_tx, bus.o_key_valid);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx_async: got %b want 1", bus.o_tx); end
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_key_valid !== 1'b0 || bus.o_key !== 7'd0) begin
      n_bad++; $display("FAIL rstmid_state: got busy %b kv %b key %0d want 0 0 0", bus.o_busy, bus.o_key_valid, bus.o_key);
    end
    @(negedge clk);
    bus.i_note = 12'h000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_rx();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_key_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || rx_byte.size() != 0) begin
      n_bad++; $display("FAIL rstmid_quiet: got %0d bad cycles, %0d bytes want 0, 0", bad, rx_byte.size());
    end
  endtask

  initial begin
    bus.i_note = '0;
    test_reset();
    test_idle_line();
    test_first_note();
    test_note_change();
    test_release();
    test_skip();
    test_ambiguous();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
